// File: rtl/pc_fetch_ctrl_if.sv
// Signal bundle between the PC fetch controller and the memory, execute unit and PC datapath.
// Handshakes: mem_rd is held while FETCH waits and the instruction word counts as accepted in
// the cycle mem_ack is sampled high; instr_valid is held through EXEC until exec_done is
// sampled high, with jmp and halt_req qualifying that same cycle.
interface pc_fetch_ctrl_if;
  logic       run;
  logic       mem_ack;
  logic       exec_done;
  logic       jmp;
  logic       halt_req;
  logic       pc_ld;
  logic       pc_oeA;
  logic       pc_oeB;
  logic       pc_din_sel;
  logic       mem_rd;
  logic       ir_ld;
  logic       instr_valid;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  run, mem_ack, exec_done, jmp, halt_req,
    output pc_ld, pc_oeA, pc_oeB, pc_din_sel, mem_rd, ir_ld,
           instr_valid, halted, fault, state
  );

  modport slave (
    output run, mem_ack, exec_done, jmp, halt_req,
    input  pc_ld, pc_oeA, pc_oeB, pc_din_sel, mem_rd, ir_ld,
           instr_valid, halted, fault, state
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Moore FSM sequencing the program counter through fetch, increment, execute and jump,
// with a bounded wait for the instruction memory acknowledge.
module pc_fetch_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CW          = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_IRLD  = 3'd2,
    S_INC   = 3'd3,
    S_EXEC  = 3'd4,
    S_JUMP  = 3'd5,
    S_HALT  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // Counter value seen in the last FETCH cycle allowed before giving up.
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Counter is zero outside FETCH, so every entry into FETCH starts a fresh count.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      S_IDLE:  if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack) begin
          state_d = S_IRLD;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == CW'(TO_LAST))) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_IRLD:  state_d = S_INC;
      S_INC:   state_d = S_EXEC;
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt_req)  state_d = S_HALT;
          else if (bus.jmp)  state_d = S_JUMP;
          else if (bus.run)  state_d = S_FETCH;
          else               state_d = S_IDLE;
        end
      end
      S_JUMP:  state_d = bus.run ? S_FETCH : S_IDLE;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_ld       = 1'b0;
    bus.pc_oeA      = 1'b0;
    bus.pc_oeB      = 1'b0;
    bus.pc_din_sel  = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.ir_ld       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    bus.fault       = 1'b0;
    bus.state       = state_q;
    unique case (state_q)
      S_IDLE:  ;
      S_FETCH: begin bus.pc_oeA = 1'b1; bus.mem_rd = 1'b1; end
      S_IRLD:  begin bus.pc_oeA = 1'b1; bus.ir_ld  = 1'b1; end
      S_INC:   begin bus.pc_oeB = 1'b1; bus.pc_ld  = 1'b1; end
      S_EXEC:  bus.instr_valid = 1'b1;
      S_JUMP:  begin bus.pc_ld = 1'b1; bus.pc_din_sel = 1'b1; end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: walks fetch, wait, timeout, jump and halt sequences
// and checks state plus the full output decode at each negative clock edge.
module tb_pc_fetch_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.MEM_TIMEOUT(15), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs {pc_ld,oeA,oeB,din_sel,mem_rd,ir_ld,instr_valid,halted,fault}
  function automatic logic [8:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd1:    return 9'b0_1_0_0_1_0_0_0_0;
      3'd2:    return 9'b0_1_0_0_0_1_0_0_0;
      3'd3:    return 9'b1_0_1_0_0_0_0_0_0;
      3'd4:    return 9'b0_0_0_0_0_0_1_0_0;
      3'd5:    return 9'b1_0_0_1_0_0_0_0_0;
      3'd6:    return 9'b0_0_0_0_0_0_0_1_0;
      3'd7:    return 9'b0_0_0_0_0_0_0_0_1;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [8:0] obs_outs();
    return {bus.pc_ld, bus.pc_oeA, bus.pc_oeB, bus.pc_din_sel, bus.mem_rd,
            bus.ir_ld, bus.instr_valid, bus.halted, bus.fault};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the state encoding and the whole output decode for that state.
  task automatic chk_state(input string tag, input logic [2:0] s);
    chk({tag, ".state"}, {6'b0, bus.state}, {6'b0, s});
    chk({tag, ".outs"}, obs_outs(), exp_outs(s));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic ack, input logic done,
                       input logic j, input logic h);
    bus.run       = r;
    bus.mem_ack   = ack;
    bus.exec_done = done;
    bus.jmp       = j;
    bus.halt_req  = h;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk_state("async_reset", 3'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    chk_state("reset", 3'd0);
    reset = 1'b0;
    tick();
    tick();
    chk_state("idle_run0", 3'd0);

    // Back-to-back instruction: 0,1,2,3,4,1
    bus.run = 1'b1;
    tick();                 chk_state("seq_fetch", 3'd1);
    bus.mem_ack = 1'b1;
    tick();                 chk_state("seq_irld", 3'd2);
    bus.mem_ack = 1'b0;
    tick();                 chk_state("seq_inc", 3'd3);
    tick();                 chk_state("seq_exec", 3'd4);
    bus.exec_done = 1'b1;
    tick();                 chk_state("seq_refetch", 3'd1);
    bus.exec_done = 1'b0;

    // Ack delayed by 3 cycles: FETCH held 4 cycles
    for (int i = 2; i <= 4; i++) begin
      tick();               chk_state($sformatf("wait_fetch%0d", i), 3'd1);
    end
    bus.mem_ack = 1'b1;
    tick();                 chk_state("wait_irld", 3'd2);
    bus.mem_ack = 1'b0;
    tick();                 chk_state("wait_inc", 3'd3);
    tick();                 chk_state("wait_exec", 3'd4);
    tick();                 chk_state("exec_hold", 3'd4);

    // Jump with run=1 -> JUMP then FETCH
    drive(1, 0, 1, 1, 0);
    tick();                 chk_state("jump_run1", 3'd5);
    drive(1, 0, 0, 0, 0);
    tick();                 chk_state("jump_to_fetch", 3'd1);
    bus.mem_ack = 1'b1;
    tick();                 chk_state("j2_irld", 3'd2);
    bus.mem_ack = 1'b0;
    tick();                 chk_state("j2_inc", 3'd3);
    tick();                 chk_state("j2_exec", 3'd4);

    // Jump with run=0 -> JUMP then IDLE
    drive(0, 0, 1, 1, 0);
    tick();                 chk_state("jump_run0", 3'd5);
    drive(0, 0, 0, 0, 0);
    tick();                 chk_state("jump_to_idle", 3'd0);

    // Timeout: 15 FETCH cycles without ack, then FAULT held
    bus.run = 1'b1;
    tick();                 chk_state("to_fetch1", 3'd1);
    for (int i = 2; i <= 15; i++) begin
      tick();               chk_state($sformatf("to_fetch%0d", i), 3'd1);
    end
    tick();                 chk_state("to_fault", 3'd7);
    for (int i = 0; i < 3; i++) begin
      tick();               chk_state("fault_hold", 3'd7);
    end
    pulse_reset();

    // Ack on the 15th FETCH cycle wins over the timeout
    bus.run = 1'b1;
    tick();                 chk_state("ack15_fetch1", 3'd1);
    for (int i = 2; i <= 15; i++) tick();
    chk_state("ack15_fetch15", 3'd1);
    bus.mem_ack = 1'b1;
    tick();                 chk_state("ack15_irld", 3'd2);
    bus.mem_ack = 1'b0;
    tick();                 chk_state("ack15_inc", 3'd3);
    tick();                 chk_state("ack15_exec", 3'd4);

    // Halt beats jmp; HALT is terminal regardless of run
    drive(1, 0, 1, 1, 1);
    tick();                 chk_state("halt", 3'd6);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();               chk_state("halt_hold", 3'd6);
    end
    pulse_reset();

    // Reset mid-FETCH clears outputs before any clock edge
    bus.run = 1'b1;
    tick();                 chk_state("mid_fetch", 3'd1);
    bus.run = 1'b0;
    pulse_reset();
    tick();                 chk_state("post_reset_idle", 3'd0);
    tick();                 chk_state("post_reset_idle2", 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Control FSM that sequences the 16-bit program counter register through instruction fetch, increment, execute hand-off and jump.
- Drives the PC's load and bus output-enables:
  - oeA puts PC on DA, the memory address bus.
  - oeB puts PC on DB, the incrementer input.
- Handshakes with instruction memory (mem_rd/mem_ack) and with the execute unit (instr_valid/exec_done).
- Detects memory timeout.

Parameters:
- MEM_TIMEOUT, 15: max consecutive FETCH cycles without mem_ack before FAULT; 0 disables the timeout.
- CW, 4: width of the wait counter; must satisfy 2^CW > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- run  in  1  level; enables fetching
- mem_ack  in  1  instruction word valid on the memory data bus this cycle
- exec_done  in  1  execute unit finished current instruction (sampled in EXEC only)
- jmp  in  1  qualifies exec_done: load PC from the jump target
- halt_req  in  1  qualifies exec_done: stop after this instruction
- pc_ld  out  1  PC load strobe
- pc_oeA  out  1  PC drives DA
- pc_oeB  out  1  PC drives DB
- pc_din_sel  out  1  PC Din mux select: 0 = incrementer (DB+1), 1 = jump target
- mem_rd  out  1  memory read request
- ir_ld  out  1  instruction register load strobe
- instr_valid  out  1  IR holds an instruction for the execute unit
- halted  out  1  FSM in HALT
- fault  out  1  FSM in FAULT
- state  out  3  current state encoding, for debug

Behaviour:
- Outputs are a pure decode of the registered state (Moore). Any output not listed for a state is 0.
- State encoding and output decode:
  - IDLE = 0: all outputs 0.
  - FETCH = 1: pc_oeA = 1, mem_rd = 1.
  - IRLD = 2: pc_oeA = 1, ir_ld = 1.
  - INC = 3: pc_oeB = 1, pc_ld = 1, pc_din_sel = 0.
  - EXEC = 4: instr_valid = 1.
  - JUMP = 5: pc_ld = 1, pc_din_sel = 1.
  - HALT = 6: halted = 1.
  - FAULT = 7: fault = 1.
- Reset (asynchronous, any time, including mid-fetch or mid-load):
  - state = IDLE, wait counter = 0.
  - Every output is 0 immediately, without waiting for a clock edge.
- Transitions:
  - IDLE: run = 1 -> FETCH; else stay.
  - FETCH:
    - mem_ack = 1 -> IRLD.
    - Else, if MEM_TIMEOUT != 0 and this is the MEM_TIMEOUT-th consecutive FETCH cycle -> FAULT.
    - Else stay; wait counter +1.
    - mem_ack in the MEM_TIMEOUT-th cycle wins over the timeout.
    - The counter clears on every entry to FETCH.
  - IRLD -> INC, unconditionally.
  - INC -> EXEC, unconditionally.
  - EXEC: exec_done = 0 -> stay. With exec_done = 1, first match wins:
    1. halt_req = 1 -> HALT; jmp is ignored.
    2. jmp = 1 -> JUMP.
    3. run = 1 -> FETCH.
    4. otherwise -> IDLE.
  - JUMP: run = 1 -> FETCH; else IDLE.
  - HALT, FAULT: terminal; only reset exits.
- run is sampled only in IDLE, EXEC (on exec_done) and JUMP. Deasserting run mid-fetch does not abort the fetch.
- Invariants:
  - pc_oeA and pc_oeB are never both 1, so no DA/DB contention from the PC.
  - pc_ld is asserted for exactly one cycle per instruction (INC), plus one in JUMP.
  - The PC value driven on DA in FETCH/IRLD is the pre-increment address.
- Latency:
  - run rising in IDLE at cycle 0 -> FETCH at cycle 1.
  - With ack at cycle 1: IRLD at 2, INC at 3, EXEC at 4.
  - Minimum 4 cycles per instruction; jump adds 1.

Test Plan:
- Reset mid-FETCH with mem_rd = 1 -> all outputs 0 without waiting for a clock edge; state = 0. After release with run = 0 -> stays IDLE.
- run = 1, mem_ack on first FETCH cycle, exec_done = 1 in first EXEC cycle -> state sequence 0,1,2,3,4,1. pc_ld = 1 only in state 3, with pc_oeB = 1 and pc_din_sel = 0.
- mem_ack delayed 3 cycles -> FETCH held 4 cycles with mem_rd = 1 and pc_oeA = 1, then IRLD. No fault.
- MEM_TIMEOUT = 15, mem_ack never -> exactly 15 FETCH cycles, then state = 7, fault = 1, held until reset. Separate case: ack on cycle 15 -> IRLD, no fault.
- exec_done with jmp = 1, run = 1 -> JUMP for one cycle (pc_ld = 1, pc_din_sel = 1), then FETCH. Case with run = 0 -> JUMP then IDLE.
- exec_done with halt_req = 1 and jmp = 1 -> HALT, halted = 1, no pc_ld pulse. Remains HALT regardless of run until reset.
